// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: opcodes, BTB entry layout and
// the PC-to-index/tag helpers used by both lookup and update paths.
package bp_pkg;

   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101;

   localparam int BP_INDEX_BITS = 4;
   localparam int BP_TAG_BITS   = 8;

   typedef struct packed {
      logic                   valid;
      logic                   useful;
      logic [BP_TAG_BITS-1:0] tag;
      logic [29:0]            target;   // target[31:2]; low bits are always 00
   } btb_entry_t;

   // Entry index: the word-aligned PC bits just above the byte offset.
   function automatic logic [BP_INDEX_BITS-1:0] bp_index(input logic [31:0] pc);
      return pc[BP_INDEX_BITS+1:2];
   endfunction

   // Tag: the PC bits directly above the index.
   function automatic logic [BP_TAG_BITS-1:0] bp_tag(input logic [31:0] pc);
      return pc[BP_INDEX_BITS+BP_TAG_BITS+1:BP_INDEX_BITS+2];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for predictor statistics; sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   // Count up on inc, hold once all-ones is reached, clear on clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/btb_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup of the fetch PC
// with same-cycle bypass of the resolving write, usefulness-guarded
// replacement, and saturating lookup/hit statistics.
module btb_target_buffer
   import bp_pkg::*;
#(
   parameter int ENTRIES    = 16,
   parameter int INDEX_BITS = BP_INDEX_BITS,   // must equal log2(ENTRIES)
   parameter int TAG_BITS   = BP_TAG_BITS,     // must match the entry layout
   parameter int CNT_BITS   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                flush_all,
   input  logic                lookup_en,
   input  logic [31:0]         PC,
   output logic                hit,
   output logic [31:0]         pred_target,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc4,
   input  logic                upd_taken,
   input  logic [31:0]         upd_target,
   output logic [CNT_BITS-1:0] lookup_cnt,
   output logic [CNT_BITS-1:0] hit_cnt
);

   btb_entry_t            table_r [ENTRIES];

   logic [INDEX_BITS-1:0] lk_index_s;
   logic [TAG_BITS-1:0]   lk_tag_s;
   btb_entry_t            lk_entry_s;

   logic [31:0]           up_pc_s;
   logic [INDEX_BITS-1:0] up_index_s;
   logic [TAG_BITS-1:0]   up_tag_s;
   btb_entry_t            up_entry_s;
   btb_entry_t            up_next_s;
   logic                  up_commit_s;
   logic                  up_match_s;
   logic                  up_write_s;
   logic                  up_wr_target_s;
   logic                  bypass_s;
   logic                  cnt_inc_s;
   logic                  hit_inc_s;
   logic                  unused_s;

   // The target's byte offset is never stored.
   assign unused_s = ^upd_target[1:0];

   assign lk_index_s  = bp_index(PC);
   assign lk_tag_s    = bp_tag(PC);
   assign lk_entry_s  = table_r[lk_index_s];

   // The resolving branch sits one word before the PC+4 that ID reports.
   assign up_pc_s     = upd_pc4 - 32'd4;
   assign up_index_s  = bp_index(up_pc_s);
   assign up_tag_s    = bp_tag(up_pc_s);
   assign up_entry_s  = table_r[up_index_s];
   assign up_commit_s = upd_valid & ~stall & ~flush_all;
   assign up_match_s  = up_entry_s.valid & (up_entry_s.tag == up_tag_s);

   // Decide the new entry contents and whether this update rewrites the target.
   always_comb begin
      up_next_s      = up_entry_s;
      up_write_s     = 1'b0;
      up_wr_target_s = 1'b0;
      if (up_commit_s) begin
         if (upd_taken) begin
            if (up_match_s) begin
               up_next_s.useful = 1'b1;
               up_next_s.target = upd_target[31:2];
               up_write_s       = 1'b1;
               up_wr_target_s   = 1'b1;
            end else if (!up_entry_s.valid || !up_entry_s.useful) begin
               up_next_s.valid  = 1'b1;
               up_next_s.useful = 1'b1;
               up_next_s.tag    = up_tag_s;
               up_next_s.target = upd_target[31:2];
               up_write_s       = 1'b1;
               up_wr_target_s   = 1'b1;
            end else begin
               // A useful resident gets one reprieve before being evicted.
               up_next_s.useful = 1'b0;
               up_write_s       = 1'b1;
            end
         end else if (up_match_s) begin
            up_next_s.useful = 1'b0;
            up_write_s       = 1'b1;
         end else begin
            up_write_s = 1'b0;
         end
      end else begin
         up_write_s = 1'b0;
      end
   end

   // Only target-carrying writes can change what the lookup reports.
   assign bypass_s = up_wr_target_s & (up_index_s == lk_index_s) & (up_tag_s == lk_tag_s);

   // Combinational lookup, forwarding a same-cycle write to the same branch.
   always_comb begin
      if (bypass_s) begin
         hit         = 1'b1;
         pred_target = {upd_target[31:2], 2'b00};
      end else if (lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s)) begin
         hit         = 1'b1;
         pred_target = {lk_entry_s.target, 2'b00};
      end else begin
         hit         = 1'b0;
         pred_target = 32'h0000_0000;
      end
   end

   // Entry array: async clear, flush drops every valid bit, else commit one write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_r[i] <= '0;
         end
      end else if (flush_all) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_r[i].valid <= 1'b0;
         end
      end else if (up_write_s) begin
         table_r[up_index_s] <= up_next_s;
      end
   end

   assign cnt_inc_s = lookup_en & ~stall;
   assign hit_inc_s = cnt_inc_s & hit;

   sat_counter #(.WIDTH(CNT_BITS)) u_lookup_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc_s),
      .clr   (1'b0),
      .count (lookup_cnt)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit_inc_s),
      .clr   (1'b0),
      .count (hit_cnt)
   );

endmodule

// File: tb/tb_btb_target_buffer.sv
// Bench for btb_target_buffer: directed scenarios plus randomized traffic,
// checked against an array-based model of the buffer and its counters.
// A second instance with 4-bit counters exercises saturation quickly.
module tb_btb_target_buffer;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush_all, lookup_en, upd_valid, upd_taken;
   logic [31:0] PC, upd_pc4, upd_target;
   logic        hit, hit_s;
   logic [31:0] pred_target, pred_target_s;
   logic [15:0] lookup_cnt, hit_cnt;
   logic [3:0]  lookup_cnt_s, hit_cnt_s;

   btb_target_buffer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush_all(flush_all),
      .lookup_en(lookup_en), .PC(PC), .hit(hit), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc4(upd_pc4), .upd_taken(upd_taken),
      .upd_target(upd_target), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
   );

   btb_target_buffer #(.CNT_BITS(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush_all(flush_all),
      .lookup_en(lookup_en), .PC(PC), .hit(hit_s), .pred_target(pred_target_s),
      .upd_valid(upd_valid), .upd_pc4(upd_pc4), .upd_taken(upd_taken),
      .upd_target(upd_target), .lookup_cnt(lookup_cnt_s), .hit_cnt(hit_cnt_s)
   );

   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model state.
   bit          m_valid  [16];
   bit          m_useful [16];
   int unsigned m_tag    [16];
   logic [31:0] m_tgt    [16];
   int unsigned m_lcnt, m_hcnt, s_lcnt, s_hcnt;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc / 4) % 16;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc / 64) % 256;
   endfunction

   // True when the update presented this cycle will store a new target.
   function automatic bit writes_target();
      logic [31:0] bp;
      int unsigned i, t;
      bp = upd_pc4 - 32'd4;
      i  = idx_of(bp);
      t  = tag_of(bp);
      if (!upd_valid || stall || flush_all || !upd_taken) return 1'b0;
      return !(m_valid[i] && m_tag[i] != t && m_useful[i]);
   endfunction

   // Expected {hit, pred_target} for a PC given current model and inputs.
   function automatic logic [32:0] model_lookup(input logic [31:0] pc);
      logic [31:0] bp;
      int unsigned i;
      bp = upd_pc4 - 32'd4;
      i  = idx_of(pc);
      if (writes_target() && idx_of(bp) == i && tag_of(bp) == tag_of(pc))
         return {1'b1, upd_target & 32'hFFFF_FFFC};
      if (m_valid[i] && m_tag[i] == tag_of(pc))
         return {1'b1, m_tgt[i]};
      return {1'b0, 32'h0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_useful[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'h0;
      end
      m_lcnt = 0; m_hcnt = 0; s_lcnt = 0; s_hcnt = 0;
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      logic [32:0] e;
      logic [31:0] bp;
      int unsigned i, t;
      e = model_lookup(PC);
      @(posedge clk);
      if (lookup_en && !stall) begin
         if (m_lcnt < 65535) m_lcnt++;
         if (s_lcnt < 15) s_lcnt++;
         if (e[32]) begin
            if (m_hcnt < 65535) m_hcnt++;
            if (s_hcnt < 15) s_hcnt++;
         end
      end
      bp = upd_pc4 - 32'd4;
      i  = idx_of(bp);
      t  = tag_of(bp);
      if (flush_all) begin
         for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      end else if (upd_valid && !stall) begin
         if (upd_taken) begin
            if (m_valid[i] && m_tag[i] == t) begin
               m_useful[i] = 1'b1;
               m_tgt[i]    = upd_target & 32'hFFFF_FFFC;
            end else if (m_valid[i] && m_useful[i]) begin
               m_useful[i] = 1'b0;
            end else begin
               m_valid[i] = 1'b1; m_useful[i] = 1'b1; m_tag[i] = t;
               m_tgt[i]   = upd_target & 32'hFFFF_FFFC;
            end
         end else if (m_valid[i] && m_tag[i] == t) begin
            m_useful[i] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; flush_all = 1'b0; lookup_en = 1'b0; upd_valid = 1'b0;
      upd_taken = 1'b0; upd_pc4 = 32'h0; upd_target = 32'h0; PC = 32'h0;
   endtask

   task automatic test_reset();
      n_vec++;
      if ({hit, pred_target, lookup_cnt, hit_cnt, lookup_cnt_s, hit_cnt_s} !== 73'h0) begin
         n_err++;
         $display("FAIL reset_state: got hit=%b tgt=%h lcnt=%h hcnt=%h, want all zero",
                  hit, pred_target, lookup_cnt, hit_cnt);
      end
   endtask

   task automatic test_cold_lookup();
      logic [32:0] e;
      PC = 32'h0000_0040; lookup_en = 1'b1;
      for (int n = 0; n < 3; n++) begin
         #1; e = model_lookup(PC); n_vec++;
         if ({hit, pred_target} !== e) begin
            n_err++;
            $display("FAIL cold_lookup: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
         end
         tick();
      end
      n_vec++;
      if (lookup_cnt !== 16'd3 || hit_cnt !== 16'd0 || m_lcnt != 3) begin
         n_err++;
         $display("FAIL cold_counts: got lcnt=%0d hcnt=%0d, want lcnt=3 hcnt=0", lookup_cnt, hit_cnt);
      end
   endtask

   task automatic test_alloc_bypass();
      logic [32:0] e;
      PC = 32'h40; upd_valid = 1'b1; upd_pc4 = 32'h44; upd_taken = 1'b1; upd_target = 32'h100;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e || e !== {1'b1, 32'h100}) begin
         n_err++;
         $display("FAIL alloc_bypass: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
      end
      tick();
      upd_valid = 1'b0;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e) begin
         n_err++;
         $display("FAIL alloc_stored: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
      end
      tick();
      n_vec++;
      if ({lookup_cnt, hit_cnt} !== {16'(m_lcnt), 16'(m_hcnt)}) begin
         n_err++;
         $display("FAIL alloc_counts: got lcnt=%0d hcnt=%0d, want lcnt=%0d hcnt=%0d", lookup_cnt, hit_cnt, m_lcnt, m_hcnt);
      end
   endtask

   task automatic test_conflict();
      logic [32:0] e;
      logic [31:0] pcs [2];
      pcs[0] = 32'h40; pcs[1] = 32'h440;
      for (int k = 0; k < 2; k++) begin
         upd_valid = 1'b1; upd_pc4 = 32'h444; upd_taken = 1'b1; upd_target = 32'h200;
         PC = pcs[k];
         #1; e = model_lookup(PC); n_vec++;
         if ({hit, pred_target} !== e) begin
            n_err++;
            $display("FAIL conflict_write%0d: got hit=%b tgt=%h, want hit=%b tgt=%h", k, hit, pred_target, e[32], e[31:0]);
         end
         tick();
         upd_valid = 1'b0;
         for (int j = 0; j < 2; j++) begin
            PC = pcs[j];
            #1; e = model_lookup(PC); n_vec++;
            if ({hit, pred_target} !== e) begin
               n_err++;
               $display("FAIL conflict_after%0d pc=%h: got hit=%b tgt=%h, want hit=%b tgt=%h",
                        k, PC, hit, pred_target, e[32], e[31:0]);
            end
         end
      end
   endtask

   task automatic test_not_taken_replace();
      logic [32:0] e;
      upd_valid = 1'b1; upd_pc4 = 32'h444; upd_taken = 1'b0; upd_target = 32'h0;
      tick();
      upd_pc4 = 32'h44; upd_taken = 1'b1; upd_target = 32'h300;
      tick();
      upd_valid = 1'b0;
      PC = 32'h40;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e || e !== {1'b1, 32'h300}) begin
         n_err++;
         $display("FAIL nt_replace: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [32:0] e;
      logic [31:0] pcs [2];
      pcs[0] = 32'hFFFF_FFFC; pcs[1] = 32'h0000_003C;
      upd_valid = 1'b1; upd_pc4 = 32'h0; upd_taken = 1'b1; upd_target = 32'h1234_5677;
      tick();
      upd_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
         PC = pcs[j];
         #1; e = model_lookup(PC); n_vec++;
         if ({hit, pred_target} !== e) begin
            n_err++;
            $display("FAIL wrap pc=%h: got hit=%b tgt=%h, want hit=%b tgt=%h", PC, hit, pred_target, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_flush();
      logic [32:0] e;
      logic [31:0] pcs [3];
      pcs[0] = 32'h40; pcs[1] = 32'hFFFF_FFFC; pcs[2] = 32'h80;
      upd_valid = 1'b1; upd_pc4 = 32'h84; upd_taken = 1'b1; upd_target = 32'h500;
      flush_all = 1'b1; PC = 32'h80;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e) begin
         n_err++;
         $display("FAIL flush_no_bypass: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
      end
      tick();
      flush_all = 1'b0; upd_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         PC = pcs[j];
         #1; e = model_lookup(PC); n_vec++;
         if ({hit, pred_target} !== e || e[32] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_miss pc=%h: got hit=%b tgt=%h, want hit=%b tgt=%h", PC, hit, pred_target, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_stall();
      logic [32:0] e;
      upd_valid = 1'b1; upd_pc4 = 32'h104; upd_taken = 1'b1; upd_target = 32'h600;
      tick();
      stall = 1'b1; lookup_en = 1'b1; upd_target = 32'h700; PC = 32'h100;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e) begin
         n_err++;
         $display("FAIL stall_lookup: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
      end
      tick();
      stall = 1'b0; upd_valid = 1'b0;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e || {lookup_cnt, hit_cnt} !== {16'(m_lcnt), 16'(m_hcnt)}) begin
         n_err++;
         $display("FAIL stall_hold: got hit=%b tgt=%h lcnt=%0d hcnt=%0d, want hit=%b tgt=%h lcnt=%0d hcnt=%0d",
                  hit, pred_target, lookup_cnt, hit_cnt, e[32], e[31:0], m_lcnt, m_hcnt);
      end
      lookup_en = 1'b0;
   endtask

   function automatic logic [31:0] pick_pc();
      logic [31:0] p;
      p = (32'($urandom_range(3)) << 6) | (32'($urandom_range(3)) << 2);
      if ($urandom_range(3) == 0) p = p | (32'($urandom) & 32'hFFFF_C000);
      if ($urandom_range(15) == 0) p = 32'($urandom);
      return p;
   endfunction

   task automatic test_random();
      logic [32:0] e;
      for (int n = 0; n < 400; n++) begin
         stall      = ($urandom_range(7) == 0);
         flush_all  = ($urandom_range(31) == 0);
         lookup_en  = 1'($urandom_range(1));
         upd_valid  = 1'($urandom_range(1));
         upd_taken  = 1'($urandom_range(1));
         PC         = pick_pc();
         upd_pc4    = pick_pc() + 32'd4;
         upd_target = 32'($urandom);
         #1; e = model_lookup(PC); n_vec++;
         if ({hit, pred_target, hit_s, pred_target_s} !== {e, e}) begin
            n_err++;
            $display("FAIL rand_lookup n=%0d pc=%h: got hit=%b tgt=%h small=%b/%h, want hit=%b tgt=%h",
                     n, PC, hit, pred_target, hit_s, pred_target_s, e[32], e[31:0]);
         end
         tick();
         n_vec++;
         if ({lookup_cnt, hit_cnt, lookup_cnt_s, hit_cnt_s} !==
             {16'(m_lcnt), 16'(m_hcnt), 4'(s_lcnt), 4'(s_hcnt)}) begin
            n_err++;
            $display("FAIL rand_counts n=%0d: got %0d/%0d small %0d/%0d, want %0d/%0d small %0d/%0d",
                     n, lookup_cnt, hit_cnt, lookup_cnt_s, hit_cnt_s, m_lcnt, m_hcnt, s_lcnt, s_hcnt);
         end
      end
      idle_inputs();
      n_vec++;
      if ({lookup_cnt_s, s_lcnt[3:0]} !== {4'hF, 4'hF}) begin
         n_err++;
         $display("FAIL small_saturate: got lcnt=%0d, want 15", lookup_cnt_s);
      end
   endtask

   task automatic test_async_reset();
      logic [32:0] e;
      upd_valid = 1'b1; upd_pc4 = 32'h44; upd_taken = 1'b1; upd_target = 32'h100;
      tick();
      PC = 32'h40; lookup_en = 1'b1;
      upd_pc4 = 32'h84; upd_target = 32'h700;
      #1; e = model_lookup(PC); n_vec++;
      if ({hit, pred_target} !== e) begin
         n_err++;
         $display("FAIL pre_reset_hit: got hit=%b tgt=%h, want hit=%b tgt=%h", hit, pred_target, e[32], e[31:0]);
      end
      #1 rst_n = 1'b0;
      #1; n_vec++;
      if ({hit, pred_target, lookup_cnt, hit_cnt, lookup_cnt_s, hit_cnt_s} !== 73'h0) begin
         n_err++;
         $display("FAIL async_reset: got hit=%b tgt=%h lcnt=%0d hcnt=%0d, want all zero",
                  hit, pred_target, lookup_cnt, hit_cnt);
      end
      model_reset();
      @(posedge clk); #1;
      upd_valid = 1'b0; lookup_en = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
         PC = (j == 0) ? 32'h40 : 32'h80;
         #1; e = model_lookup(PC); n_vec++;
         if ({hit, pred_target} !== e || e[32] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drop_update pc=%h: got hit=%b tgt=%h, want hit=%b tgt=%h",
                     PC, hit, pred_target, e[32], e[31:0]);
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #2;
      test_reset();
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      test_cold_lookup();
      test_alloc_bypass();
      test_conflict();
      test_not_taken_replace();
      test_wrap();
      test_flush();
      test_stall();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/btb_target_buffer.md
Name: btb_target_buffer

Overview:
- Direct-mapped branch target buffer in the IF stage, beside the direction predictor.
- Looks up the fetch PC combinationally and supplies a predicted target, so the PC mux can redirect in the same cycle the predictor asserts taken.
- The ID stage writes resolved BEQ/BNE outcomes and targets back into the buffer.
- Keeps saturating lookup and hit counters for predictor experiments.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two.
- INDEX_BITS, 4, log2(ENTRIES).
- TAG_BITS, 8, number of PC bits stored per entry above the index.
- CNT_BITS, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall; blocks updates and counting.
- flush_all  in  1  synchronous invalidate of every entry.
- lookup_en  in  1  IF holds a BEQ/BNE; qualifies counting only.
- PC  in  32  current fetch PC.
- hit  out  1  valid entry with a tag match for PC.
- pred_target  out  32  predicted target; 0 when hit=0.
- upd_valid  in  1  ID has resolved a branch this cycle.
- upd_pc4  in  32  PC+4 of the resolving branch.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  32  computed branch target.
- lookup_cnt  out  CNT_BITS  saturating count of counted lookups.
- hit_cnt  out  CNT_BITS  saturating count of counted hits.

Behaviour:
- Reset is asynchronous and active-low: when rst_n is low, all valid, useful, tag and target fields clear immediately, as do both counters. Reset must also take effect in the middle of an update.
- Entry fields: valid (1 bit), useful (1 bit), tag (TAG_BITS), target (bits 31:2; bits 1:0 are always reported as 00).
- Lookup addressing:
  - index = PC[INDEX_BITS+1:2]
  - tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
- Lookup is combinational with zero latency.
  - hit = valid & (stored tag == tag), taken over the registered table contents.
- Same-cycle bypass: if a write is committing this cycle (rules below) to the same index and tag as the lookup, then:
  - hit follows the value being written.
  - pred_target equals upd_target with bits 1:0 forced to 00.
- Update addressing: branch PC = upd_pc4 - 4, computed in 32-bit modulo arithmetic (upd_pc4 = 0 wraps to 0xFFFFFFFC). Index and tag are taken from the branch PC exactly as for lookup.
- Update rules, applied when upd_valid & !stall & !flush_all:
  - Taken, and the entry is a tag match: rewrite the target and set useful=1.
  - Taken, and the entry is invalid: allocate it (valid=1, useful=1, write tag and target).
  - Taken, and a different tag is present with useful=1: clear useful only; do not replace.
  - Taken, and a different tag is present with useful=0: replace the entry (valid=1, useful=1, new tag and target).
  - Not taken, and the entry is a tag match: clear useful; valid stays set.
  - Not taken, and no tag match: no change.
- Every write commits at the rising edge of clk.
- flush_all has priority over any update: at the next edge all valid bits clear; tags and targets are don't-care.
- stall blocks updates and counting; lookup outputs stay live during a stall.
- Counters, when lookup_en & !stall:
  - lookup_cnt increments by 1.
  - hit_cnt increments by 1 if hit.
  - Both saturate at all-ones and do not wrap.
- Lookup and update to different indices in the same cycle are fully independent.

Decomposition:
- Shared package (bp_pkg) holds:
  - Opcode constants BEQ = 6'b000100 and BNE = 6'b000101.
  - The btb_entry_t struct {valid, useful, tag, target[31:2]}.
  - Helper functions bp_index() and bp_tag().
- One sub-module, sat_counter (parameter WIDTH; inputs inc and clr; output count), instantiated twice for the statistics counters.
- The entry array and lookup/bypass logic stay in the top module.

Test Plan:
- Reset, then PC=0x00000040, lookup_en=1 for 3 cycles -> hit=0, pred_target=0, lookup_cnt=3, hit_cnt=0.
- upd_valid=1, upd_pc4=0x44, upd_taken=1, upd_target=0x100; next cycle PC=0x40 -> hit=1, pred_target=0x100. In the write cycle itself, PC=0x40 also gives hit=1 via the bypass.
- Conflict on index 0, with the entry holding branch 0x40:
  - First taken update to branch 0x440 (same index, different tag) -> useful cleared, PC=0x40 still hits.
  - Second taken update to branch 0x440 -> entry replaced; PC=0x440 hits with the new target, PC=0x40 misses.
- Not-taken update of branch 0x40, then a taken update of 0x440 -> replaced on the first attempt.
- Assert flush_all in the same cycle as a taken update -> next cycle every PC misses. Separately, assert rst_n=0 mid-cycle -> hit drops immediately and counters read 0.
- Preload lookup_cnt to 0xFFFE, then 3 counted lookups -> lookup_cnt stays at 0xFFFF. Also update with upd_pc4=0 -> entry written at index 15 with tag 0xFF.
